byte_serializer: RTL
====================

# byte_serializer

Parallel-in, serial-out transmitter: the read-out end of the team's parallel load registers. Accepts one WIDTH-bit word per valid/ready handshake, then shifts it out one bit per accepted serial beat under a downstream ready. An optional even-parity bit may be appended to each frame. It sits between register-bank outputs and any single-wire downstream consumer.

## Interface
- WIDTH, 8: data word width in bits, at least 2.
- MSB_FIRST, 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  the word on D is offered.
- D  in  WIDTH  parallel word, sampled on the accept edge.
- in_ready  out  1  serializer can accept a word.
- sd  out  1  current serial bit.
- sd_valid  out  1  sd holds a frame bit.
- sd_ready  in  1  downstream takes sd this cycle.
- sd_last  out  1  sd is the final bit of the frame.
- busy  out  1  a frame is in progress.

## Operation
- States: IDLE, SHIFT, PAR (PAR exists only with the parity feature).
- IDLE:
  - in_ready=1, sd_valid=0.
  - An accept is in_valid && in_ready at a clock edge.
  - On accept: load D into the shift register, clear bit_cnt and the parity accumulator, go to SHIFT.
- SHIFT:
  - sd_valid=1.
  - sd = shreg[WIDTH-1] when MSB_FIRST=1, else shreg[0].
  - A beat completes when sd_valid && sd_ready at an edge. On a beat: shift toward the output end, bit_cnt+1, parity ^= sd.
  - When sd_ready=0: sd, sd_valid and sd_last hold their values unchanged.
  - The beat with bit_cnt==WIDTH-1 goes to PAR, or to IDLE when parity is compiled out.
- PAR:
  - sd = parity ^ 0 (even parity over the WIDTH data bits), sd_valid=1, sd_last=1.
  - The beat returns the block to IDLE.
- bit_cnt width is $clog2(WIDTH+1). No wrap occurs, because the counter is cleared on every load.
- busy = (state != IDLE).
- in_ready=0 whenever busy. Words offered while busy are not taken; the upstream holds them.
- in_valid while in IDLE with rst=1 is ignored. Reset has priority over every other event.

## Timing
- All outputs are registered.
- Reset values: in_ready=0, sd=0, sd_valid=0, sd_last=0, busy=0, state=IDLE, shreg=0, bit_cnt=0.
- in_ready rises on the first edge after rst deasserts.
- Accept at edge N: in_ready=0 and sd_valid=1, with the first bit on sd, from edge N onward (latency 1 cycle).
- With sd_ready held high:
  - Frame length is WIDTH cycles, or WIDTH+1 with parity.
  - sd_valid falls and in_ready rises on the edge of the final beat.
  - The next accept can occur one cycle later. Back-to-back frames therefore have exactly one idle cycle between them.
- rst asserted mid-frame: at that edge every output goes to its reset value and the partial frame is discarded. No sd_last is issued.

## Configuration
- SERIALIZER_PARITY_EN defined:
  - The PAR state is present.
  - The even-parity bit follows the data bits.
  - sd_last is asserted only on the parity bit.
- SERIALIZER_PARITY_EN undefined:
  - No PAR state and no parity accumulator.
  - sd_last is asserted on data bit WIDTH-1.

## Structure
- Package serializer_pkg holds:
  - the state typedef (enum IDLE, SHIFT, PAR);
  - localparam for the bit_cnt width.
- Single module. The shift register and counter are simple enough that no sub-module is warranted.

## Test plan
- Reset, then idle: with rst=1 for 2 cycles, all outputs are 0. One cycle after release, in_ready=1 and sd_valid=0.
- MSB_FIRST=1, parity compiled in, D=8'b10100101, sd_ready=1:
  - sd sequence is 1,0,1,0,0,1,0,1, then parity bit 0.
  - sd_last is asserted only on the 9th bit.
  - in_ready returns 1 after the 9th beat.
- MSB_FIRST=0, parity compiled out, D=8'b11110000:
  - sd sequence is 0,0,0,0,1,1,1,1.
  - sd_last is asserted on the 8th bit. There is no 9th beat.
- Backpressure: D=8'b01010101, with sd_ready dropped for 3 cycles after the 2nd beat.
  - sd and sd_valid hold steady during the stall.
  - The frame completes intact, in 3 extra cycles.
- Busy rejection: while a frame is in flight, in_valid=1 with D=8'b00001111.
  - in_ready stays 0 and the current frame is unaffected.
  - The word is accepted on the cycle after the frame ends, and its bits follow.
- Mid-frame reset: rst=1 for 1 cycle after the 4th beat.
  - Outputs return to their reset values and sd_last never asserts.
  - A new word, 8'b10000000, then serializes correctly.

Source files
------------

// File: rtl/serializer_pkg.sv
// -----------------------------------------------------------------------------
// serializer_pkg
// Shared types and sizing helpers for byte_serializer.
//   state_e        : frame FSM states (PAR is only reachable when the parity
//                    feature is compiled in)
//   cnt_width()    : bit counter width for a given word width
//   DEFAULT_CNT_W  : bit counter width for the default 8-bit word
// -----------------------------------------------------------------------------
package serializer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      PAR   = 2'd2
   } state_e;

   localparam int DEFAULT_WIDTH = 8;

   // The counter must be able to hold WIDTH, hence WIDTH+1 codes.
   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

   localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/byte_serializer.sv
// -----------------------------------------------------------------------------
// byte_serializer
// Parallel-in, serial-out transmitter. Takes one WIDTH-bit word per
// in_valid/in_ready handshake and shifts it out one bit per sd_valid/sd_ready
// beat. With SERIALIZER_PARITY_EN defined an even-parity bit is appended to
// every frame and sd_last marks that parity bit; otherwise sd_last marks the
// final data bit.
//
// Parameters
//   WIDTH      word width in bits (>= 2)
//   MSB_FIRST  1: bit WIDTH-1 goes out first, 0: bit 0 goes out first
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   in_valid   in   word on D is offered
//   D          in   parallel word, captured on the accept edge
//   in_ready   out  serializer can take a word
//   sd         out  current serial bit
//   sd_valid   out  sd holds a frame bit
//   sd_ready   in   downstream takes sd this cycle
//   sd_last    out  sd is the final bit of the frame
//   busy       out  a frame is in progress
//
// Build option: SERIALIZER_PARITY_EN
// -----------------------------------------------------------------------------
module byte_serializer
   import serializer_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] D,
   output logic             in_ready,
   output logic             sd,
   output logic             sd_valid,
   input  logic             sd_ready,
   output logic             sd_last,
   output logic             busy
);

   localparam int BIT_CNT_W = cnt_width(WIDTH);
   localparam logic [BIT_CNT_W-1:0] LAST_IDX = BIT_CNT_W'(WIDTH - 1);
`ifndef SERIALIZER_PARITY_EN
   localparam logic [BIT_CNT_W-1:0] PENULT_IDX = BIT_CNT_W'(WIDTH - 2);
`endif

   state_e                 state_q;
   logic [WIDTH-1:0]       shreg_q;
   logic [WIDTH-1:0]       shreg_d;
   logic [BIT_CNT_W-1:0]   bit_cnt_q;
   logic                   in_ready_q;
   logic                   sd_q;
   logic                   sd_valid_q;
   logic                   sd_last_q;
   logic                   busy_q;
`ifdef SERIALIZER_PARITY_EN
   logic                   parity_q;
`endif

   logic                   first_bit_d;  // bit that leads a freshly loaded word
   logic                   next_bit_d;   // bit that reaches the output after a shift
   logic                   accept;
   logic                   beat;

   assign accept = in_valid & in_ready_q;
   assign beat   = sd_valid_q & sd_ready;

   // NOTE: every variable assigned in always_comb gets a default first so no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      shreg_d     = shreg_q;
      first_bit_d = 1'b0;
      next_bit_d  = 1'b0;
      if (MSB_FIRST) begin
         shreg_d     = {shreg_q[WIDTH-2:0], 1'b0};
         first_bit_d = D[WIDTH-1];
         next_bit_d  = shreg_q[WIDTH-2];
      end else begin
         shreg_d     = {1'b0, shreg_q[WIDTH-1:1]};
         first_bit_d = D[0];
         next_bit_d  = shreg_q[1];
      end
   end

   // Frame FSM with all outputs held in flops. sd is kept as its own register
   // (rather than a tap of shreg_q) because the parity bit shares the pin.
   // NOTE: sequential state uses non-blocking assignments so every flop sees
   // the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         shreg_q    <= '0;
         bit_cnt_q  <= '0;
         in_ready_q <= 1'b0;
         sd_q       <= 1'b0;
         sd_valid_q <= 1'b0;
         sd_last_q  <= 1'b0;
         busy_q     <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
         parity_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               // First edge after reset release raises in_ready.
               in_ready_q <= 1'b1;
               if (accept) begin
                  shreg_q    <= D;
                  bit_cnt_q  <= '0;
                  state_q    <= SHIFT;
                  busy_q     <= 1'b1;
                  in_ready_q <= 1'b0;
                  sd_valid_q <= 1'b1;
                  sd_q       <= first_bit_d;
                  sd_last_q  <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
                  parity_q   <= 1'b0;
`endif
               end
            end

            SHIFT: begin
               if (beat) begin
                  shreg_q   <= shreg_d;
                  bit_cnt_q <= bit_cnt_q + 1'b1;
`ifdef SERIALIZER_PARITY_EN
                  parity_q  <= parity_q ^ sd_q;
                  if (bit_cnt_q == LAST_IDX) begin
                     // Even parity: the accumulated XOR including this bit.
                     state_q   <= PAR;
                     sd_q      <= parity_q ^ sd_q;
                     sd_last_q <= 1'b1;
                  end else begin
                     sd_q      <= next_bit_d;
                  end
`else
                  if (bit_cnt_q == LAST_IDX) begin
                     state_q    <= IDLE;
                     busy_q     <= 1'b0;
                     in_ready_q <= 1'b1;
                     sd_valid_q <= 1'b0;
                     sd_q       <= 1'b0;
                     sd_last_q  <= 1'b0;
                  end else begin
                     sd_q      <= next_bit_d;
                     // The bit coming up is the final data bit.
                     sd_last_q <= (bit_cnt_q == PENULT_IDX);
                  end
`endif
               end
            end

`ifdef SERIALIZER_PARITY_EN
            PAR: begin
               if (beat) begin
                  state_q    <= IDLE;
                  busy_q     <= 1'b0;
                  in_ready_q <= 1'b1;
                  sd_valid_q <= 1'b0;
                  sd_q       <= 1'b0;
                  sd_last_q  <= 1'b0;
               end
            end
`endif

            default: begin
               state_q    <= IDLE;
               busy_q     <= 1'b0;
               in_ready_q <= 1'b0;
               sd_valid_q <= 1'b0;
               sd_q       <= 1'b0;
               sd_last_q  <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready = in_ready_q;
   assign sd       = sd_q;
   assign sd_valid = sd_valid_q;
   assign sd_last  = sd_last_q;
   assign busy     = busy_q;

endmodule
